// File: rtl/countdown_timer_ctrl.sv
// Run/pause/done controller for a two-digit BCD down-counter: key edges, prescaled count ticks, alarm blink.
// Optional build macro ALARM_TIMEOUT_EN adds an automatic DONE->IDLE exit after ALARM_CYCLES cycles.
module countdown_timer_ctrl #(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned BLINK_DIV    = 12_500_000,
    parameter int unsigned ALARM_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic [7:0] data_sw,
    input  logic [7:0] count_in,
    input  logic       tc_in,
    output logic       load_n,
    output logic       ena,
    output logic       ena_cnt,
    output logic [7:0] data_init,
    output logic [1:0] state,
    output logic       alarm,
    output logic       blink
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    if (TICK_DIV < 2 || BLINK_DIV < 1 || ALARM_CYCLES < 1) begin : g_bad_cfg
        $error("countdown_timer_ctrl: TICK_DIV must be >=2, BLINK_DIV and ALARM_CYCLES >=1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, pause_q;
    logic [7:0]       data_init_q, data_init_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             ena_q;
    logic             ena_cnt_q, ena_cnt_d;
    logic             alarm_q, alarm_d;
    logic             blink_q, blink_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;

    logic start_rise, pause_rise;
    logic data_ok, data_zero;
    logic timeout_hit;

    assign start_rise = start_key & ~start_q;
    assign pause_rise = pause_key & ~pause_q;
    assign data_ok    = (data_init_q[7:4] <= 4'd9) && (data_init_q[3:0] <= 4'd9);
    assign data_zero  = (data_init_q == 8'h00);

`ifdef ALARM_TIMEOUT_EN
    localparam int unsigned TMR_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALARM_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Cycles spent in DONE since entry; cleared whenever DONE is (re)entered.
    always_comb begin
        tmr_d = '0;
        if (state_q == ST_DONE && state_d == ST_DONE) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign timeout_hit = (tmr_q == TMR_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b1;
            pause_q     <= 1'b1;
            data_init_q <= 8'h00;
            presc_q     <= '0;
            ena_q       <= 1'b0;
            ena_cnt_q   <= 1'b0;
            alarm_q     <= 1'b0;
            blink_q     <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_key;
            pause_q     <= pause_key;
            data_init_q <= data_init_d;
            presc_q     <= presc_d;
            ena_q       <= 1'b1;
            ena_cnt_q   <= ena_cnt_d;
            alarm_q     <= alarm_d;
            blink_q     <= blink_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_init_d = data_init_q;
        presc_d     = presc_q;
        ena_cnt_d   = 1'b0;
        alarm_d     = 1'b0;
        blink_d     = 1'b0;
        blk_cnt_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    if (data_zero) begin
                        state_d = ST_DONE;
                    end else if (data_ok) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (tc_in && count_in == 8'h00) begin
                    state_d = ST_DONE;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end else if (pause_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start_rise || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap coinciding with leaving RUN is held, so the tick is issued after resume rather than lost.
        if (state_q == ST_IDLE) begin
            data_init_d = data_sw;
            presc_d     = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (presc_q == PRE_LAST) begin
                presc_d   = '0;
                ena_cnt_d = ~tc_in;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end

        alarm_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) begin
                blink_d   = 1'b1;
                blk_cnt_d = '0;
            end else if (blk_cnt_q == BLK_LAST) begin
                blink_d   = ~blink_q;
                blk_cnt_d = '0;
            end else begin
                blink_d   = blink_q;
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    assign load_n    = (state_q != ST_IDLE);
    assign ena       = ena_q;
    assign ena_cnt   = ena_cnt_q;
    assign data_init = data_init_q;
    assign state     = state_q;
    assign alarm     = alarm_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl with a BCD down-counter model downstream, cycle reference model and directed/random stimulus.
module tb_countdown_timer_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int BLINK_DIV    = 2;
    localparam int ALARM_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_key, pause_key;
    logic [7:0] data_sw;
    logic       load_n, ena, ena_cnt, alarm, blink;
    logic [7:0] data_init;
    logic [1:0] state;
    logic [7:0] cnt = 8'h00;
    logic       tc;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;

    always #5 clk = ~clk;

    countdown_timer_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .BLINK_DIV   (BLINK_DIV),
        .ALARM_CYCLES(ALARM_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_key(start_key),
        .pause_key(pause_key),
        .data_sw  (data_sw),
        .count_in (cnt),
        .tc_in    (tc),
        .load_n   (load_n),
        .ena      (ena),
        .ena_cnt  (ena_cnt),
        .data_init(data_init),
        .state    (state),
        .alarm    (alarm),
        .blink    (blink)
    );

    // Downstream two-digit BCD down-counter
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) return 8'h00;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always @(posedge clk) begin
        if (!load_n) cnt <= data_init;
        else if (ena && ena_cnt) cnt <= bcd_dec(cnt);
    end
    assign tc = (cnt == 8'h00);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, RUN-phase modulo TICK_DIV, and age within DONE
    int         m_state = 0;
    int         m_phase = 0;
    int         m_age   = 0;
    logic [7:0] m_di    = 8'h00;
    bit         m_tick  = 0, m_blink = 0, m_alarm = 0, m_ena = 0;
    bit         m_sprev = 1, m_pprev = 1;

    always @(posedge clk) begin
        bit sr, pr, ok;
        int nxt;
        if (reset) begin
            m_state = 0; m_phase = 0; m_age = 0; m_di = 8'h00;
            m_tick = 0; m_blink = 0; m_alarm = 0; m_ena = 0;
            m_sprev = 1; m_pprev = 1;
        end else begin
            sr  = start_key && !m_sprev;
            pr  = pause_key && !m_pprev;
            ok  = (m_di[7:4] <= 4'd9) && (m_di[3:0] <= 4'd9);
            nxt = m_state;
            case (m_state)
                0: if (sr) begin
                       if (m_di == 8'h00) nxt = 3;
                       else if (ok) nxt = 1;
                   end
                1: if (tc && cnt == 8'h00) nxt = 3;
                   else if (pr) nxt = 2;
                2: if (sr) nxt = 0;
                   else if (pr) nxt = 1;
                default: begin
                    if (sr) nxt = 0;
`ifdef ALARM_TIMEOUT_EN
                    else if (m_age == ALARM_CYCLES - 1) nxt = 0;
`endif
                end
            endcase
            m_tick = (m_state == 1) && (nxt == 1) && (m_phase == TICK_DIV - 1) && !tc;
            if (m_state == 0) m_phase = 0;
            else if (m_state == 1 && nxt == 1) m_phase = (m_phase + 1) % TICK_DIV;
            if (m_state == 0) m_di = data_sw;
            m_age   = (nxt == 3 && m_state == 3) ? m_age + 1 : 0;
            m_alarm = (nxt == 3);
            m_blink = (nxt == 3) && (((m_age / BLINK_DIV) % 2) == 0);
            m_state = nxt;
            m_ena   = 1;
            m_sprev = start_key;
            m_pprev = pause_key;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",     state,     m_state);
            chk("load_n",    load_n,    (m_state != 0) ? 1 : 0);
            chk("ena",       ena,       m_ena);
            chk("ena_cnt",   ena_cnt,   m_tick);
            chk("data_init", data_init, m_di);
            chk("alarm",     alarm,     m_alarm);
            chk("blink",     blink,     m_blink);
        end
    end

    task automatic pulse_start();
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_key = 1'b1;
        @(negedge clk);
        pause_key = 1'b0;
    endtask

    task automatic set_preset(input logic [7:0] v);
        data_sw = v;
        @(negedge clk);
    endtask

    initial begin
        int         k_tick, k_done, k_res, r;
        logic [5:0] bexp;
        reset = 1'b1; start_key = 1'b0; pause_key = 1'b0; data_sw = 8'h00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_ena", ena, 0);
        chk("rst_load_n", load_n, 0);
        chk("rst_data_init", data_init, 0);
        @(negedge clk); reset = 1'b0;

        // Preset 03: tick every 4 cycles, DONE one cycle after 00, blink pattern
        set_preset(8'h03);
        pulse_start();
        chk("run_entry", state, 1);
        chk("run_cnt", cnt, 8'h03);
        k_tick = 0; k_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ena_cnt && k_tick == 0) k_tick = k;
            if (state == 2'd3) begin k_done = k; break; end
        end
        chk("first_tick", k_tick, 4);
        chk("done_latency", k_done, 14);
        chk("done_cnt", cnt, 0);
        chk("done_alarm", alarm, 1);
        bexp = 6'b110011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk("blink_seq", blink, bexp[i]);
        end
        @(negedge clk);
        pulse_start();
        chk("done_exit", state, 0);

        // Preset 12: pause after two ticks, hold, resume with remaining phase
        set_preset(8'h12);
        pulse_start();
        chk("run12", state, 1);
        for (int k = 0; k < 40 && cnt != 8'h10; k++) @(negedge clk);
        pulse_pause();
        chk("pause_state", state, 2);
        repeat (10) @(negedge clk);
        chk("pause_hold_cnt", cnt, 8'h10);
        chk("pause_hold_state", state, 2);
        pause_key = 1'b1;
        k_res = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (cnt == 8'h09) begin k_res = k; break; end
        end
        chk("resume_phase", k_res, 5);
        @(negedge clk); pause_key = 1'b0;
        @(negedge clk);

        // Abort from PAUSE reloads; start+pause together in PAUSE also aborts
        pulse_pause();
        chk("pause2", state, 2);
        pulse_start();
        chk("abort_state", state, 0);
        chk("abort_load_n", load_n, 0);
        @(negedge clk);
        chk("reload_cnt", cnt, 8'h12);
        pulse_start();
        chk("rerun", state, 1);
        pulse_pause();
        start_key = 1'b1; pause_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0; pause_key = 1'b0;
        chk("both_keys", state, 0);

        // Invalid BCD ignored, zero preset goes straight to DONE
        set_preset(8'h1A);
        pulse_start();
        chk("bad_bcd", state, 0);
        set_preset(8'h00);
        pulse_start();
        chk("zero_done", state, 3);
        chk("zero_alarm", alarm, 1);
`ifdef ALARM_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 15) chk("timeout_pre", state, 3);
            if (k == 16) chk("timeout_exit", state, 0);
        end
        @(negedge clk);
`else
        repeat (100) @(negedge clk);
        chk("done_hold", state, 3);
        pulse_start();
        chk("done_hold_exit", state, 0);
`endif

        // Key held through reset gives no edge
        set_preset(8'h12);
        start_key = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        start_key = 1'b0;
        @(negedge clk);
        chk("held_key", state, 0);

        // Reset mid-RUN
        pulse_start();
        chk("run_before_rst", state, 1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state", state, 0);
        chk("midrst_ena", ena, 0);
        chk("midrst_ena_cnt", ena_cnt, 0);
        chk("midrst_data_init", data_init, 0);
        @(negedge clk); reset = 1'b0;

        // Randomized traffic checked by the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 599) == 0);
            start_key = ($urandom_range(0, 15) == 0);
            pause_key = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 5);
            if (r == 0) data_sw = 8'h00;
            else if (r == 1) data_sw = 8'($urandom);
            else data_sw = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        end
        reset = 1'b0; start_key = 1'b0; pause_key = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Control stage that drives the two-digit BCD down-counter, which sits directly downstream of this block. It turns start/pause key levels into a run/pause/done state machine, and generates that counter's load strobe, enable and one-cycle count ticks from a programmable prescaler. It watches the counter's count and terminal-count outputs to raise an alarm with a blink output for the 7-segment/LED stage.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per count tick (≥2).
- BLINK_DIV, 12_500_000: clk cycles per blink toggle in DONE (≥1).
- ALARM_CYCLES, 500_000_000: DONE auto-exit time, used only with ALARM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic rises on it.
- reset  in  1  synchronous, active-high reset.
- start_key  in  1  debounced start/abort key level, active-high.
- pause_key  in  1  debounced pause/resume key level, active-high.
- data_sw  in  8  BCD preset from switches, tens in [7:4], ones in [3:0].
- count_in  in  8  BCD count fed back from the counter.
- tc_in  in  1  counter terminal count (count==00).
- load_n  out  1  counter load strobe, active-low.
- ena  out  1  counter global enable.
- ena_cnt  out  1  one-cycle count tick.
- data_init  out  8  registered preset, wired to the counter's load data.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- alarm  out  1  high in DONE.
- blink  out  1  toggling output in DONE.

## Operation
- Edge detect: start_rise = start_key & ~start_q; pause_rise likewise.
  - start_q and pause_q reset to 1, so a key held through reset gives no edge.
- data_init is loaded from data_sw every cycle in IDLE and frozen in all other states.
- load_n = 0 iff state==IDLE. ena = 1 in every state after reset.
- Prescaler runs 0..TICK_DIV-1, counting only in RUN.
  - ena_cnt = 1 for one cycle when prescaler==TICK_DIV-1 in RUN and tc_in=0; the prescaler wraps to 0 on that cycle.
- IDLE:
  - start_rise with a valid, nonzero data_init goes to RUN and clears the prescaler. Valid means both nibbles ≤9.
  - start_rise with data_init==00 goes to DONE.
  - start_rise with an invalid nibble is ignored; the block stays in IDLE.
  - pause_rise is ignored.
- RUN:
  - tc_in=1 goes to DONE; ena_cnt is suppressed in that cycle.
  - Otherwise pause_rise goes to PAUSE.
  - start_rise is ignored.
- PAUSE:
  - ena_cnt=0 and the prescaler holds its value.
  - start_rise goes to IDLE (abort and reload). It wins over a simultaneous pause_rise.
  - Otherwise pause_rise returns to RUN, and the prescaler resumes from its held value.
- DONE:
  - alarm=1.
  - blink starts at 1 and toggles every BLINK_DIV cycles.
  - start_rise goes to IDLE.
- blink=0 and alarm=0 outside DONE.
- count_in is used only for the tc_in check: the RUN→DONE transition requires tc_in=1 and count_in==00.
- Reset values: state=IDLE, load_n=0, ena=0, ena_cnt=0, data_init=00, alarm=0, blink=0, prescaler=0.

## Timing
- All outputs are registered except load_n, which is decoded directly from state.
- A key edge sampled in cycle n changes state in cycle n+1.
- data_init lags data_sw by 1 cycle. The counter loads data_init on the last IDLE edge, so count_in equals the preset in the first RUN cycle.
- Ticks fall at RUN cycles TICK_DIV, 2·TICK_DIV, and so on, measured from RUN entry.
- DONE is entered 1 cycle after the counter shows 00, because tc_in is sampled from the counter register.
- Reset mid-operation: the next cycle is IDLE with all reset values. The prescaler and blink counters are cleared.

## Configuration
- ALARM_TIMEOUT_EN defined: DONE returns to IDLE automatically after ALARM_CYCLES cycles; start_rise still exits early.
- ALARM_TIMEOUT_EN undefined: DONE is held until start_rise or reset, and no timeout counter is built.

## Test plan
Bench settings: TICK_DIV=4, BLINK_DIV=2, ALARM_CYCLES=16, with the real down-counter downstream.
- Preset 8'h03, pulse start → ena_cnt every 4 cycles; count goes 03→02→01→00; state=DONE and alarm=1 one cycle after 00; blink toggles every 2 cycles.
- Preset 8'h12, start, then pause after 2 ticks → count holds 10, no ena_cnt. Pause again → ticks resume with the remaining prescaler phase.
- PAUSE, then start → state=IDLE, load_n=0, count reloads 8'h12. Start and pause on the same cycle in PAUSE → IDLE.
- Preset 8'h1A, start → stays IDLE. Preset 8'h00, start → DONE on the next cycle.
- Start key held high through reset and released → no transition. Reset asserted mid-RUN → next cycle state=00, ena=0, ena_cnt=0, data_init=00.
- With ALARM_TIMEOUT_EN: DONE → IDLE after 16 cycles. Without it: DONE persists for 100 cycles.
